fetch_ctrl: RTL

//  Drives the PC's control inputs (pc_enable, branch_true, new_addr) and consumes pc_output.

---
 rtl/fetch_ctrl_pkg.sv | 19 +
 rtl/fetch_queue.sv | 54 +++++
 rtl/fetch_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the instruction fetch controller: FSM state encoding and
// the {addr, inst} record carried through the fetch queue.
package fetch_ctrl_pkg;

    localparam int FETCH_ADDR_W = 32;
    localparam int FETCH_INST_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] addr;
        logic [FETCH_INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of fetched {addr, inst} pairs; flush clears it and takes
// priority over a same-cycle push or pop.
module fetch_queue
    import fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_push,
    input  logic           i_pop,
    input  logic           i_flush,
    input  fetch_entry_t   i_data,
    output fetch_entry_t   o_head,
    output logic [CW-1:0]  o_count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t    r_mem [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

    // Storage, pointers (power-of-two depth, so they wrap naturally) and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= {PW{1'b0}};
            r_rptr  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else if (i_flush) begin
            r_wptr  <= {PW{1'b0}};
            r_rptr  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + PW'(1'b1);
            end
            if (i_pop) begin
                r_rptr <= r_rptr + PW'(1'b1);
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: steers the PC, issues one outstanding imem
// request at a time, queues responses for decode and handles redirects.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int INST_W = FETCH_INST_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_pc_output,
    output logic              o_pc_enable,
    output logic              o_branch_true,
    output logic [ADDR_W-1:0] o_new_addr,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [INST_W-1:0] i_imem_rdata,
    input  logic              i_redirect_valid,
    input  logic [ADDR_W-1:0] i_redirect_addr,
    output logic              o_inst_valid,
    input  logic              i_inst_ready,
    output logic [ADDR_W-1:0] o_inst_addr,
    output logic [INST_W-1:0] o_inst_data
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    logic              r_imem_req;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [ADDR_W-1:0] w_imem_addr_nxt;
    logic              w_ack_wait;
    logic              w_push;
    logic              w_pop;
    logic              w_room_after;
    logic [CW-1:0]     w_count;
    logic [CW-1:0]     w_count_after;
    fetch_entry_t      w_push_entry;
    fetch_entry_t      w_head;

    assign o_imem_req   = r_imem_req;
    assign o_imem_addr  = r_imem_addr;
    assign o_inst_valid = (w_count != {CW{1'b0}});
    assign o_inst_addr  = w_head.addr;
    assign o_inst_data  = w_head.inst;

    // A redirect discards the response and the head being consumed this cycle.
    assign w_ack_wait    = (r_state == WAIT) && i_imem_ack;
    assign w_push        = w_ack_wait && !i_redirect_valid;
    assign w_pop         = o_inst_valid && i_inst_ready && !i_redirect_valid;
    assign w_count_after = w_count + CW'(1'b1) - CW'(w_pop);
    assign w_room_after  = (w_count_after < FULL_C);

    assign w_push_entry.addr = r_imem_addr;
    assign w_push_entry.inst = i_imem_rdata;

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (i_redirect_valid),
        .i_data  (w_push_entry),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // Next-state and next fetch address.
    always_comb begin
        w_state_nxt     = r_state;
        w_imem_addr_nxt = r_imem_addr;
        case (r_state)
            IDLE: begin
                if (!i_redirect_valid && (w_count < FULL_C)) begin
                    w_state_nxt     = WAIT;
                    w_imem_addr_nxt = i_pc_output;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (i_imem_ack) begin
                    if (i_redirect_valid) begin
                        w_state_nxt = IDLE;
                    end else if (w_room_after) begin
                        w_state_nxt     = WAIT;
                        w_imem_addr_nxt = r_imem_addr + ADDR_W'(1'b1);
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (i_redirect_valid) begin
                    w_state_nxt = KILL;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            KILL: begin
                if (i_imem_ack) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = KILL;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // PC control: redirect loads the target, an accepted fetch advances by one.
    always_comb begin
        o_pc_enable   = 1'b0;
        o_branch_true = 1'b0;
        o_new_addr    = {ADDR_W{1'b0}};
        if (rst) begin
            o_pc_enable   = 1'b0;
            o_branch_true = 1'b0;
        end else if (i_redirect_valid) begin
            o_pc_enable   = 1'b1;
            o_branch_true = 1'b1;
            o_new_addr    = i_redirect_addr;
        end else if (w_ack_wait) begin
            o_pc_enable = 1'b1;
        end else begin
            o_pc_enable = 1'b0;
        end
    end

    // State, request strobe and fetch address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_imem_req  <= 1'b0;
            r_imem_addr <= {ADDR_W{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_imem_req  <= (w_state_nxt != IDLE);
            r_imem_addr <= w_imem_addr_nxt;
        end
    end

endmodule
